// File: rtl/uart_rx_sampler_if.sv
// Serial-side signal bundle of the UART Rx sampler: raw line in, aligned
// data/strobe pair and frame status out.
interface uart_rx_sampler_if;
    logic serial_in;
    logic serial_out;
    logic data_is_available;
    logic rx_busy;
    logic rx_done;
    logic framing_error;
    logic parity_error;

    modport master (
        output serial_in,
        input  serial_out,
        input  data_is_available,
        input  rx_busy,
        input  rx_done,
        input  framing_error,
        input  parity_error
    );

    modport slave (
        input  serial_in,
        output serial_out,
        output data_is_available,
        output rx_busy,
        output rx_done,
        output framing_error,
        output parity_error
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART Rx front end: synchroniser, start-bit qualification and mid-bit strobe
// timing for a downstream SIPO. Optional even-parity check under RX_PARITY_EN.
module uart_rx_sampler #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLKS_PER_BIT     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_rx_sampler_if.slave   rx_if
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(INPUT_DATA_WIDTH + 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(INPUT_DATA_WIDTH - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_serial_out;
    logic [TICK_W-1:0]  r_tick;
    logic [TICK_W-1:0]  w_tick_nxt;
    logic [BIT_W-1:0]   r_bits;
    logic [BIT_W-1:0]   w_bits_nxt;
    logic               r_strobe;
    logic               w_strobe_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_ferr;
    logic               w_ferr_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_rx_s;

`ifdef RX_PARITY_EN
    logic               r_par_acc;
    logic               w_par_acc_nxt;
    logic               r_par_bad;
    logic               w_par_bad_nxt;
    logic               r_perr;
    logic               w_perr_nxt;
`endif

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser plus one alignment flop so serial_out lines up with the strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_serial_out <= 1'b1;
        end else begin
            r_sync1      <= rx_if.serial_in;
            r_sync2      <= r_sync1;
            r_serial_out <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bits   <= '0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_ferr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_bits   <= w_bits_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
            r_ferr   <= w_ferr_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par_acc <= 1'b0;
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_par_acc <= w_par_acc_nxt;
            r_par_bad <= w_par_bad_nxt;
            r_perr    <= w_perr_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick;
        w_bits_nxt   = r_bits;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_ferr_nxt   = 1'b0;
`ifdef RX_PARITY_EN
        w_par_acc_nxt = r_par_acc;
        w_par_bad_nxt = r_par_bad;
        w_perr_nxt    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_tick_nxt  = '0;
                end
            end
            // Start bit must still be low half a bit later, otherwise it was a glitch
            S_START: begin
                if (r_tick == TICK_HALF) begin
                    w_tick_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_bits_nxt  = '0;
`ifdef RX_PARITY_EN
                        w_par_acc_nxt = 1'b0;
                        w_par_bad_nxt = 1'b0;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
            S_DATA: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt   = '0;
                    w_strobe_nxt = 1'b1;
                    w_bits_nxt   = r_bits + BIT_W'(1);
`ifdef RX_PARITY_EN
                    w_par_acc_nxt = r_par_acc ^ w_rx_s;
                    if (r_bits == BITS_LAST) w_state_nxt = S_PARITY;
`else
                    if (r_bits == BITS_LAST) w_state_nxt = S_STOP;
`endif
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt    = '0;
                    w_par_bad_nxt = r_par_acc ^ w_rx_s;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt = '0;
`ifdef RX_PARITY_EN
                    w_perr_nxt = r_par_bad;
`endif
                    if (w_rx_s) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign rx_if.serial_out        = r_serial_out;
    assign rx_if.data_is_available = r_strobe;
    assign rx_if.rx_busy           = r_busy;
    assign rx_if.rx_done           = r_done;
    assign rx_if.framing_error     = r_ferr;
`ifdef RX_PARITY_EN
    assign rx_if.parity_error      = r_perr;
`else
    assign rx_if.parity_error      = 1'b0;
`endif

endmodule
